// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative 64-bit multiplier.
//   DEF_WIDTH  default operand/result width (also the iteration count)
//   OP_*       operation select encodings driven by decode
//   state_t    controller state encoding
//   ZERO_REG   register index that is never written back
//   isHighHalf true when the operation returns the upper product half
package seq_multiplier_pkg;

   localparam int DEF_WIDTH = 64;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_SMULH = 2'b10;

   localparam logic [4:0] ZERO_REG = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Op 11 is reserved and behaves as MUL, so only UMULH/SMULH select high.
   function automatic logic isHighHalf(input logic [1:0] op);
      return (op == OP_UMULH) || (op == OP_SMULH);
   endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add datapath: multiplicand/multiplier registers, 128-bit accumulator
// and iteration counter. One multiplier bit (LSB first) is consumed per step.
//   clk, rstN     clock and asynchronous active-low reset
//   load          capture operands, clear accumulator and counter
//   step          perform one iteration
//   mcandIn       unsigned multiplicand
//   mplierIn      unsigned multiplier
//   lastIter      the step taken this cycle is the final one
//   prodNext      accumulator value after this cycle's step (combinational)
module mul_shift_add_core
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcandIn,
   input  logic [WIDTH-1:0]   mplierIn,
   output logic               lastIter,
   output logic [2*WIDTH-1:0] prodNext
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   iterCnt;
   logic [WIDTH:0]     partial;

   // Right-shifting accumulator: the multiplicand is always added into the
   // upper half and the whole accumulator moves right one place per step.
   // The carry out of the add lands in the top bit after the shift, so the
   // 128-bit result never loses a bit.
   always_comb begin
      partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      prodNext = {partial, acc[WIDTH-1:1]};
   end

   assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         iterCnt <= '0;
      end else if (load) begin
         mcand   <= mcandIn;
         mplier  <= mplierIn;
         acc     <= '0;
         iterCnt <= '0;
      end else if (step) begin
         acc     <= prodNext;
         mplier  <= mplier >> 1;
         iterCnt <= iterCnt + 1'b1;
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the LEGv8 datapath (MUL/UMULH/SMULH).
//   Clk, Reset_n   clock and asynchronous active-low reset
//   Start          request, accepted only in IDLE
//   Op             00 MUL, 01 UMULH, 10 SMULH, 11 treated as MUL
//   BusA, BusB     operands (Rn, Rm), needed only at the accepting edge
//   RW             destination register number
//   Busy           high in RUN and DONE; decode stalls the PC on it
//   Done           one-cycle pulse, Result valid
//   Result         selected product half, held until the next result
//   WrReg          latched destination register
//   WrEn           Done qualified by WrReg != 31
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for Start, operands captured on acceptance
// ST_RUN  | one multiplier bit per cycle for WIDTH cycles
// ST_DONE | Done/WrEn pulse, Result stable, then back to idle
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [4:0]       RW,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [4:0]       WrReg,
   output logic             WrEn
);

   state_t             state;
   logic [1:0]         opLat;
   logic               signFlag;
   logic               isSmulh;
   logic               loadCore;
   logic               stepCore;
   logic               lastIter;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [2*WIDTH-1:0] prodNext;
   logic [2*WIDTH-1:0] prodSigned;

   // For SMULH the core multiplies magnitudes; -(-2^63) wraps to 2^63,
   // which is exactly the unsigned magnitude we need.
   always_comb begin
      isSmulh  = (Op == OP_SMULH);
      magA     = (isSmulh && BusA[WIDTH-1]) ? -BusA : BusA;
      magB     = (isSmulh && BusB[WIDTH-1]) ? -BusB : BusB;
      loadCore = (state == ST_IDLE) && Start;
      stepCore = (state == ST_RUN);
   end

   assign prodSigned = signFlag ? -prodNext : prodNext;

   mul_shift_add_core #(.WIDTH(WIDTH)) uCore (
      .clk      (Clk),
      .rstN     (Reset_n),
      .load     (loadCore),
      .step     (stepCore),
      .mcandIn  (magA),
      .mplierIn (magB),
      .lastIter (lastIter),
      .prodNext (prodNext)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         opLat    <= OP_MUL;
         signFlag <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         WrEn     <= 1'b0;
         WrReg    <= '0;
         Result   <= '0;
      end else begin
         Done <= 1'b0;
         WrEn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state    <= ST_RUN;
                  Busy     <= 1'b1;
                  opLat    <= Op;
                  WrReg    <= RW;
                  signFlag <= isSmulh && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
               end
            end
            ST_RUN: begin
               // The final step's sum is taken straight from the core so
               // the result is registered on the same edge that enters DONE.
               if (lastIter) begin
                  state  <= ST_DONE;
                  Done   <= 1'b1;
                  WrEn   <= (WrReg != ZERO_REG);
                  Result <= isHighHalf(opLat) ? prodSigned[2*WIDTH-1:WIDTH]
                                              : prodSigned[WIDTH-1:0];
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic [1:0]  Op;
   logic [63:0] BusA;
   logic [63:0] BusB;
   logic [4:0]  RW;
   logic        Busy;
   logic        Done;
   logic [63:0] Result;
   logic [4:0]  WrReg;
   logic        WrEn;

   int checkCnt = 0;
   int errCnt   = 0;

   seq_multiplier dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Start   (Start),
      .Op      (Op),
      .BusA    (BusA),
      .BusB    (BusB),
      .RW      (RW),
      .Busy    (Busy),
      .Done    (Done),
      .Result  (Result),
      .WrReg   (WrReg),
      .WrEn    (WrEn)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the product computed directly at 128 bits.
   function automatic logic [63:0] refModel(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
      logic [127:0]        u;
      logic signed [127:0] s;
      u = {64'd0, a} * {64'd0, b};
      s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      case (op)
         2'b01:   return u[127:64];
         2'b10:   return s[127:64];
         default: return u[63:0];
      endcase
   endfunction

   // Called just after a posedge. Accepts on the next edge, then follows the
   // operation through Done and the return to idle.
   task automatic runOp(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rw, input bit repulse);
      logic [63:0] expRes;
      int lat;
      expRes = refModel(op, a, b);
      Op = op; BusA = a; BusB = b; RW = rw; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom};
      Op = 2'($urandom); RW = 5'($urandom);
      chk({tag, " busy_rise"}, Busy, 1);
      lat = 0;
      while (!Done && lat < 100) begin
         Start = repulse && (lat == 10);
         @(posedge Clk); #1;
         lat++;
      end
      Start = 1'b0;
      chk({tag, " latency"}, lat, 64);
      chk({tag, " result"}, Result, expRes);
      chk({tag, " wrreg"}, WrReg, rw);
      chk({tag, " wren"}, WrEn, (rw != 5'd31));
      chk({tag, " busy_done"}, Busy, 1);
      @(posedge Clk); #1;
      chk({tag, " done_fall"}, {Done, WrEn, Busy}, 0);
      chk({tag, " result_hold"}, Result, expRes);
   endtask

   initial begin
      logic [63:0] corners [6];
      logic [63:0] ra, rb;
      int doneSeen;
      corners[0] = 64'h0;
      corners[1] = 64'h1;
      corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      corners[3] = 64'h8000_0000_0000_0000;
      corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;
      corners[5] = 64'hDEAD_BEEF_0123_4567;

      Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; BusA = '0; BusB = '0; RW = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk); Reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("idle", {Busy, Done, WrEn, WrReg, Result}, 0);
      end
      @(posedge Clk); #1;

      runOp("mul7x6", 2'b00, 64'd7, 64'd6, 5'd3, 1'b0);
      runOp("umulh_ones", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b0);
      chk("umulh_ones value", Result, 64'hFFFF_FFFF_FFFF_FFFE);
      runOp("mul_ones", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b0);
      chk("mul_ones value", Result, 64'd1);
      runOp("smulh_m1x1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 1'b0);
      chk("smulh_m1x1 value", Result, 64'hFFFF_FFFF_FFFF_FFFF);
      runOp("smulh_min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5, 1'b0);
      chk("smulh_min value", Result, 64'h4000_0000_0000_0000);
      runOp("mul_x31", 2'b00, 64'd5, 64'd5, 5'd31, 1'b0);
      chk("mul_x31 value", Result, 64'd25);
      runOp("repulse", 2'b00, 64'd1234, 64'd5678, 5'd7, 1'b1);
      runOp("op11", 2'b11, 64'h1_0000_0001, 64'h3, 5'd2, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
         runOp($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), ra, rb, 5'($urandom), 1'b0);
      end

      // Reset in the middle of an operation.
      Op = 2'b00; BusA = 64'd99; BusB = 64'd77; RW = 5'd6; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (30) @(posedge Clk);
      #1 Reset_n = 1'b0;
      #1;
      chk("midrst outputs", {Busy, Done, WrEn, WrReg, Result}, 0);
      @(posedge Clk); @(negedge Clk);
      Reset_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge Clk);
         if (Done || Busy) doneSeen++;
      end
      chk("midrst no_done", doneSeen, 0);
      @(posedge Clk); #1;
      runOp("after_rst", 2'b00, 64'd3, 64'd4, 5'd8, 1'b0);
      chk("after_rst value", Result, 64'd12);

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end

endmodule
